lfsr_wb_sequencer: RTL and testbench
====================================

Name: lfsr_wb_sequencer

Overview:
- Pipelined Wishbone master that sequences the on-chip Wishbone LFSR slave.
- On a start command it writes a seed to the slave, then issues COUNT single reads. Each returned byte goes out on a valid/ready stream.
- Sits between the tt_um top-level pins and the LFSR slave, replacing direct pin-driven bus cycles.
- Slave contract: address 0 is the seed register (write); address 1 returns the next LFSR byte (read, advances the LFSR).

Parameters:
- DW, 8, Wishbone data width and stream width.
- CNT_W, 8, width of the read-count input and internal counter.
- TIMEOUT, 15, maximum cycles to wait for i_wb_ack after a strobe is accepted; range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- seed  in  DW  seed value, captured on an accepted start.
- count  in  CNT_W  number of reads, captured on an accepted start.
- busy  out  1  high from an accepted start until DONE/ERR is entered.
- done  out  1  one-cycle pulse when the sequence completes.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- out_data  out  DW  read byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- o_wb_cyc  out  1  bus cycle active.
- o_wb_stb  out  1  strobe.
- o_wb_we  out  1  1 = write.
- o_wb_addr  out  1  slave address.
- o_wb_data  out  DW  write data.
- i_wb_stall  in  1  slave stall; the strobe is accepted on a cycle with stb && !stall.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_data  in  DW  read data, valid with ack.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, err, out_valid, o_wb_cyc, o_wb_stb, o_wb_we and o_wb_addr are all 0; out_data and o_wb_data are 0. Counters are cleared.
- Reset asserted mid-transaction drops cyc/stb immediately; no cleanup cycle is issued.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, PUSH, DONE, ERR.
- IDLE: on start=1, latch seed and count, clear err, and go to WR_REQ next cycle. busy rises the same edge.
- start is ignored in every state other than IDLE.
- WR_REQ: cyc=1, stb=1, we=1, addr=0, data=seed. Hold all of these unchanged while i_wb_stall=1.
- WR_REQ exit: on acceptance, go to WR_WAIT with stb=0 and cyc=1.
- WR_WAIT: on i_wb_ack, drop cyc. If count==0, go to DONE; else go to RD_REQ.
- RD_REQ: cyc=1, stb=1, we=0, addr=1, with the same stall rule. On acceptance, go to RD_WAIT.
- RD_WAIT: on i_wb_ack, capture i_wb_data into out_data, set out_valid, drop cyc, and go to PUSH.
- Ack in the same cycle as acceptance: it is not legal for this slave. Ack is only honoured in *_WAIT states; an ack in any other state is ignored.
- PUSH: hold out_valid and out_data stable until out_ready=1. On that cycle, clear out_valid and decrement the remaining count.
  - remaining count reaches 0: go to DONE.
  - otherwise: go to RD_REQ.
- Bus back-pressure: no new bus cycle is issued while a byte is pending, so there is at most one outstanding transaction.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Timeout: a counter resets on strobe acceptance and increments each cycle in WR_WAIT/RD_WAIT.
  - If it reaches TIMEOUT with no ack: drop cyc, set err=1, busy=0, go to ERR.
  - ERR lasts one cycle, then IDLE. No done pulse is given.
  - err stays high until the next accepted start.
- Stall time in *_REQ states is not timed.
- Latency (no stall, ack 1 cycle after acceptance, out_ready tied 1):
  - start to first out_valid = 5 cycles.
  - Each further byte adds 3 cycles.
- o_wb_stb is never high without o_wb_cyc. o_wb_cyc never stays high outside WR_*/RD_* states.

Test Plan:
- Basic sequence: seed=0xA5, count=3, zero stall, ack after 1 cycle, out_ready=1 -> one write (addr0, data 0xA5) and three reads (addr1). Bytes appear in order from the slave model. done pulses once, busy high throughout, err=0.
- count=0: start with seed=0x01 -> only the write cycle occurs, done pulses, out_valid never rises.
- Stall and back-pressure: i_wb_stall high for 4 cycles on each request, out_ready low for 3 cycles per byte. Required:
  - stb, addr and we are held stable during stall.
  - out_data is held stable while out_ready is low.
  - no second read is issued while out_valid=1.
- Timeout: slave never acks the 2nd read, TIMEOUT=15 -> cyc drops exactly 15 cycles after acceptance. err=1, busy=0, no done. The next start clears err and a full run completes.
- start while busy: pulse start during RD_WAIT with different seed/count -> ignored, and the original sequence finishes unchanged.
- Async reset: assert rst_n=0 mid RD_WAIT, off the clock edge -> cyc, stb, out_valid and busy go to 0 immediately. After release the block sits in IDLE and a new start works.

Source files
------------

// File: rtl/lfsr_wb_sequencer.sv
// lfsr_wb_sequencer
// Pipelined Wishbone master that drives the on-chip LFSR slave. An accepted
// start writes the seed to slave address 0, then performs `count` single reads
// of address 1. Each returned byte is presented on a valid/ready stream before
// the next read is issued, so at most one bus transaction is ever outstanding.
// A wait for acknowledge longer than TIMEOUT cycles aborts the sequence and
// raises a sticky err flag.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start, seed, count     command pulse (IDLE only) with seed and read count
//   busy, done, err        status: running, one-cycle completion, sticky timeout
//   out_data, out_valid,   read byte stream towards the consumer
//   out_ready
//   o_wb_cyc, o_wb_stb,    Wishbone master request signals
//   o_wb_we, o_wb_addr,
//   o_wb_data
//   i_wb_stall, i_wb_ack,  Wishbone slave response signals
//   i_wb_data
module lfsr_wb_sequencer #(
  parameter int DW      = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DW-1:0]    seed,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic             o_wb_addr,
  output logic [DW-1:0]    o_wb_data,
  input  logic             i_wb_stall,
  input  logic             i_wb_ack,
  input  logic [DW-1:0]    i_wb_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_PUSH,
    S_DONE,
    S_ERR
  } state_t;

  // The wait counter expires on the cycle it has already counted TIMEOUT-1,
  // so the bus is released exactly TIMEOUT cycles after strobe acceptance.
  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [DW-1:0]    seed_q;
  logic [CNT_W-1:0] remain_q;
  logic [7:0]       tmo_q;
  logic             err_q;
  logic [DW-1:0]    data_q;
  logic             tmo_hit;

  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An ack is only meaningful while waiting; in a *_REQ state it cannot belong
  // to this master's strobe and is ignored by construction.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (!i_wb_stall) state_nxt = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (i_wb_ack) begin
          state_nxt = (remain_q == '0) ? S_DONE : S_RD_REQ;
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_RD_REQ: begin
        if (!i_wb_stall) state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_wb_ack) begin
          state_nxt = S_PUSH;
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
        end
      end
      S_PUSH: begin
        if (out_ready) begin
          state_nxt = (remain_q == CNT_ONE) ? S_DONE : S_RD_REQ;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: command capture, remaining-read count, ack wait timer, sticky
  // error and the captured read byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q   <= '0;
      remain_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            seed_q   <= seed;
            remain_q <= count;
            err_q    <= 1'b0;
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          if (!i_wb_stall) tmo_q <= '0;
        end
        S_WR_WAIT: begin
          if (!i_wb_ack) begin
            if (tmo_hit) err_q <= 1'b1;
            else         tmo_q <= tmo_q + 8'd1;
          end
        end
        S_RD_WAIT: begin
          if (i_wb_ack) begin
            data_q <= i_wb_data;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_PUSH: begin
          if (out_ready) remain_q <= remain_q - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Bus and status outputs are decoded from state alone, so an asynchronous
  // reset drops cyc/stb/busy/out_valid without waiting for a clock edge.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = 1'b0;
    o_wb_data = '0;
    case (state)
      S_WR_REQ: begin
        busy      = 1'b1;
        o_wb_cyc  = 1'b1;
        o_wb_stb  = 1'b1;
        o_wb_we   = 1'b1;
        o_wb_data = seed_q;
      end
      S_WR_WAIT: begin
        busy     = 1'b1;
        o_wb_cyc = 1'b1;
      end
      S_RD_REQ: begin
        busy      = 1'b1;
        o_wb_cyc  = 1'b1;
        o_wb_stb  = 1'b1;
        o_wb_addr = 1'b1;
      end
      S_RD_WAIT: begin
        busy     = 1'b1;
        o_wb_cyc = 1'b1;
      end
      S_PUSH: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign err      = err_q;
  assign out_data = data_q;

endmodule

// File: tb/tb_lfsr_wb_sequencer.sv
// tb_lfsr_wb_sequencer
// Self-checking bench for lfsr_wb_sequencer. A negedge-driven agent plays the
// LFSR slave (configurable stall, ack one cycle after acceptance, optional
// missing ack) and the stream consumer (configurable back-pressure), and logs
// bus operations, delivered bytes and protocol violations. Expected bytes come
// from an independent LFSR reference applied to the seed.
module tb_lfsr_wb_sequencer;

  localparam int DW    = 8;
  localparam int CNT_W = 8;
  localparam int TMO   = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic [7:0]    count = '0;
  logic          busy, done, err;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_stall = 1'b0;
  logic          i_wb_ack = 1'b0;
  logic [DW-1:0] i_wb_data = '0;

  lfsr_wb_sequencer #(.DW(DW), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .count(count),
    .busy(busy), .done(done), .err(err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  int total = 0;
  int bad = 0;

  // agent configuration and logs
  int stall_cfg = 0, stall_left = 0, ready_cfg = 0, ready_left = 0, noack_rd = 0;
  logic          ack_pending = 1'b0;
  logic [7:0]    ack_data = '0, slave_lfsr = '0, last_wr_data = '0;
  int n_wr = 0, n_rd = 0, bad_op = 0, last_acc = 0;
  int unstable = 0, hold_bad = 0, overlap_bad = 0, proto_bad = 0;
  int done_cnt = 0, valid_cnt = 0;
  logic prev_stalled = 1'b0, prev_we = 1'b0, prev_addr = 1'b0, prev_hold = 1'b0;
  logic [7:0] prev_wdata = '0, prev_out = '0;
  logic [7:0] obs_q[$];
  int         obs_cyc[$];

  // Reference LFSR of the slave: Galois form, taps 0xB8.
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  // Byte n (0-based) the slave returns after being seeded with s.
  function automatic logic [7:0] nth_byte(input logic [7:0] s, input int n);
    logic [7:0] x;
    x = s;
    for (int i = 0; i <= n; i++) x = lfsr_step(x);
    return x;
  endfunction

  // Slave + consumer agent, acting on each falling edge.
  initial begin : agent
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_wb_ack     = 1'b0;
        i_wb_stall   = 1'b0;
        ack_pending  = 1'b0;
        prev_stalled = 1'b0;
        prev_hold    = 1'b0;
      end else begin
        i_wb_ack    = ack_pending;
        i_wb_data   = ack_pending ? ack_data : 8'h00;
        ack_pending = 1'b0;
        if (o_wb_stb && !o_wb_cyc) proto_bad++;
        if (out_valid && o_wb_cyc) overlap_bad++;
        if (done) done_cnt++;
        if (out_valid) valid_cnt++;
        if (prev_stalled && (o_wb_stb !== 1'b1 || o_wb_we !== prev_we ||
            o_wb_addr !== prev_addr || o_wb_data !== prev_wdata)) unstable++;
        if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_out)) hold_bad++;
        prev_stalled = 1'b0;
        if (o_wb_cyc && o_wb_stb) begin
          if (stall_left > 0) begin
            i_wb_stall   = 1'b1;
            stall_left--;
            prev_stalled = 1'b1;
            prev_we      = o_wb_we;
            prev_addr    = o_wb_addr;
            prev_wdata   = o_wb_data;
          end else begin
            i_wb_stall = 1'b0;
            stall_left = stall_cfg;
            last_acc   = cyc_cnt + 1;
            if (o_wb_we) begin
              n_wr++;
              if (o_wb_addr !== 1'b0) bad_op++;
              slave_lfsr   = o_wb_data;
              last_wr_data = o_wb_data;
              ack_pending  = 1'b1;
              ack_data     = 8'h00;
            end else begin
              n_rd++;
              if (o_wb_addr !== 1'b1) bad_op++;
              slave_lfsr = lfsr_step(slave_lfsr);
              if (n_rd != noack_rd) begin
                ack_pending = 1'b1;
                ack_data    = slave_lfsr;
              end
            end
          end
        end else begin
          i_wb_stall = 1'b0;
        end
        prev_hold = 1'b0;
        if (out_valid) begin
          if (ready_left > 0) begin
            out_ready = 1'b0;
            ready_left--;
            prev_hold = 1'b1;
            prev_out  = out_data;
          end else begin
            out_ready = 1'b1;
            obs_q.push_back(out_data);
            obs_cyc.push_back(cyc_cnt);
            ready_left = ready_cfg;
          end
        end else begin
          out_ready = (ready_cfg == 0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic setup(input int s, input int r, input int noack);
    obs_q.delete();
    obs_cyc.delete();
    n_wr = 0; n_rd = 0; bad_op = 0; unstable = 0; hold_bad = 0;
    overlap_bad = 0; proto_bad = 0; done_cnt = 0; valid_cnt = 0;
    stall_cfg = s; stall_left = s; ready_cfg = r; ready_left = r;
    noack_rd = noack;
  endtask

  // Pulses start for one cycle; `at` is the cycle count when start was driven.
  // Inputs are scrambled afterwards so only latched values can be used.
  task automatic do_start(input logic [7:0] s, input logic [7:0] c, output int at);
    tick();
    seed = s; count = c; start = 1'b1;
    at = cyc_cnt;
    tick();
    start = 1'b0;
    seed  = 8'($urandom);
    count = 8'($urandom);
  endtask

  task automatic wait_end(input int budget, output bit ended, output int end_cyc,
                          output int busy_low, output int last_cyc_hi);
    ended = 1'b0; end_cyc = 0; busy_low = 0; last_cyc_hi = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done || err) begin
        ended = 1'b1;
        end_cyc = cyc_cnt;
        break;
      end
      if (!busy) busy_low++;
      if (o_wb_cyc) last_cyc_hi = cyc_cnt;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({busy, done, err, out_valid, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000000",
               {busy, done, err, out_valid, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr});
    end
    total++;
    if (out_data !== 8'h00 || o_wb_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_data: got out_data=%h o_wb_data=%h want 00 00", out_data, o_wb_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int at, ec, bl, lh;
    bit ended;
    setup(0, 0, 0);
    do_start(8'hA5, 8'd3, at);
    wait_end(200, ended, ec, bl, lh);
    total++;
    if (!ended || err !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL basic_end: got ended=%0d err=%b done=%b want 1 0 1", ended, err, done);
    end
    total++;
    if (bl != 0) begin
      bad++;
      $display("[TB] FAIL basic_busy: got %0d busy-low cycles want 0", bl);
    end
    total++;
    if (n_wr != 1 || last_wr_data !== 8'hA5 || n_rd != 3 || bad_op != 0) begin
      bad++;
      $display("[TB] FAIL basic_bus: got wr=%0d data=%h rd=%0d badop=%0d want 1 a5 3 0",
               n_wr, last_wr_data, n_rd, bad_op);
    end
    total++;
    if (obs_q.size() != 3) begin
      bad++;
      $display("[TB] FAIL basic_nbytes: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_q[i] !== nth_byte(8'hA5, i)) begin
          bad++;
          $display("[TB] FAIL basic_byte%0d: got %h want %h", i, obs_q[i], nth_byte(8'hA5, i));
        end
      end
      total++;
      if (obs_cyc[0] - at != 5 || obs_cyc[1] - obs_cyc[0] != 3 || obs_cyc[2] - obs_cyc[1] != 3) begin
        bad++;
        $display("[TB] FAIL basic_latency: got %0d/%0d/%0d want 5/3/3", obs_cyc[0] - at,
                 obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
      end
    end
    tick();
    tick();
    total++;
    if (done_cnt != 1 || proto_bad != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_done: got pulses=%0d proto=%0d busy=%b want 1 0 0",
               done_cnt, proto_bad, busy);
    end
  endtask

  task automatic test_count_zero();
    int at, ec, bl, lh;
    bit ended;
    setup(0, 0, 0);
    do_start(8'h01, 8'd0, at);
    wait_end(100, ended, ec, bl, lh);
    tick();
    tick();
    total++;
    if (!ended || done_cnt != 1 || n_wr != 1 || last_wr_data !== 8'h01 || n_rd != 0) begin
      bad++;
      $display("[TB] FAIL zero_seq: got ended=%0d done=%0d wr=%0d data=%h rd=%0d want 1 1 1 01 0",
               ended, done_cnt, n_wr, last_wr_data, n_rd);
    end
    total++;
    if (valid_cnt != 0) begin
      bad++;
      $display("[TB] FAIL zero_valid: got %0d valid cycles want 0", valid_cnt);
    end
  endtask

  task automatic test_stall_backpressure();
    int at, ec, bl, lh;
    bit ended;
    logic [7:0] s;
    s = 8'($urandom);
    setup(4, 3, 0);
    do_start(s, 8'd3, at);
    wait_end(400, ended, ec, bl, lh);
    total++;
    if (!ended || done !== 1'b1 || n_rd != 3) begin
      bad++;
      $display("[TB] FAIL stall_end: got ended=%0d done=%b rd=%0d want 1 1 3", ended, done, n_rd);
    end
    total++;
    if (unstable != 0 || hold_bad != 0 || overlap_bad != 0) begin
      bad++;
      $display("[TB] FAIL stall_stable: got unstable=%0d hold=%0d overlap=%0d want 0 0 0",
               unstable, hold_bad, overlap_bad);
    end
    total++;
    if (obs_q.size() != 3) begin
      bad++;
      $display("[TB] FAIL stall_nbytes: got %0d want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_q[i] !== nth_byte(s, i)) begin
          bad++;
          $display("[TB] FAIL stall_byte%0d: got %h want %h", i, obs_q[i], nth_byte(s, i));
        end
      end
      total++;
      if (obs_cyc[0] - at != 16 || obs_cyc[1] - obs_cyc[0] != 10) begin
        bad++;
        $display("[TB] FAIL stall_latency: got %0d/%0d want 16/10",
                 obs_cyc[0] - at, obs_cyc[1] - obs_cyc[0]);
      end
    end
  endtask

  task automatic test_timeout();
    int at, ec, bl, lh;
    bit ended;
    logic [7:0] s;
    s = 8'($urandom);
    setup(0, 0, 2);
    do_start(s, 8'd3, at);
    wait_end(300, ended, ec, bl, lh);
    total++;
    if (!ended || err !== 1'b1 || busy !== 1'b0 || o_wb_cyc !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tmo_flags: got ended=%0d err=%b busy=%b cyc=%b want 1 1 0 0",
               ended, err, busy, o_wb_cyc);
    end
    total++;
    if (ec - last_acc != TMO || lh != ec - 1) begin
      bad++;
      $display("[TB] FAIL tmo_cycles: got drop=%0d lastcyc=%0d want %0d %0d",
               ec - last_acc, lh - last_acc, TMO, TMO - 1);
    end
    total++;
    if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== nth_byte(s, 0))) begin
      bad++;
      $display("[TB] FAIL tmo_bytes: got n=%0d want 1 byte %h", obs_q.size(), nth_byte(s, 0));
    end
    tick();
    tick();
    tick();
    total++;
    if (err !== 1'b1 || done_cnt != 0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tmo_sticky: got err=%b done=%0d busy=%b want 1 0 0", err, done_cnt, busy);
    end
    s = 8'($urandom);
    setup(0, 0, 0);
    do_start(s, 8'd2, at);
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL tmo_clear: got err=%b busy=%b want 0 1", err, busy);
    end
    wait_end(200, ended, ec, bl, lh);
    total++;
    if (!ended || done !== 1'b1 || obs_q.size() != 2 ||
        (obs_q.size() == 2 && (obs_q[0] !== nth_byte(s, 0) || obs_q[1] !== nth_byte(s, 1)))) begin
      bad++;
      $display("[TB] FAIL tmo_rerun: got ended=%0d done=%b n=%0d want 1 1 2", ended, done, obs_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int at, ec, bl, lh;
    bit ended, seen;
    logic [7:0] s;
    int c;
    s = 8'($urandom);
    c = $urandom_range(2, 4);
    setup(0, 0, 0);
    do_start(s, 8'(c), at);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_wb_cyc && !o_wb_stb && n_rd == 1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL busy_reach: got no RD_WAIT want RD_WAIT within 50 cycles");
    end
    seed = ~s; count = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    wait_end(300, ended, ec, bl, lh);
    tick();
    tick();
    tick();
    total++;
    if (!ended || done_cnt != 1 || n_wr != 1 || n_rd != c || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_ignore: got ended=%0d done=%0d wr=%0d rd=%0d busy=%b want 1 1 1 %0d 0",
               ended, done_cnt, n_wr, n_rd, busy, c);
    end
    total++;
    if (obs_q.size() != c) begin
      bad++;
      $display("[TB] FAIL busy_nbytes: got %0d want %0d", obs_q.size(), c);
    end else begin
      for (int i = 0; i < c; i++) begin
        total++;
        if (obs_q[i] !== nth_byte(s, i)) begin
          bad++;
          $display("[TB] FAIL busy_byte%0d: got %h want %h", i, obs_q[i], nth_byte(s, i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int at, ec, bl, lh;
    bit ended;
    logic [7:0] s;
    setup(0, 0, 1);
    do_start(8'($urandom), 8'd2, at);
    for (int i = 0; i < 50; i++) begin
      if (o_wb_cyc && !o_wb_stb && n_rd == 1) break;
      tick();
    end
    tick();
    total++;
    if (o_wb_cyc !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL areset_pre: got cyc=%b busy=%b want 1 1", o_wb_cyc, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_wb_cyc, o_wb_stb, out_valid, busy} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL areset_now: got %b want 0000", {o_wb_cyc, o_wb_stb, out_valid, busy});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if ({busy, done, err, o_wb_cyc} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL areset_idle: got %b want 0000", {busy, done, err, o_wb_cyc});
    end
    s = 8'($urandom);
    setup(0, 0, 0);
    do_start(s, 8'd2, at);
    wait_end(200, ended, ec, bl, lh);
    total++;
    if (!ended || done !== 1'b1 || n_wr != 1 || obs_q.size() != 2 ||
        (obs_q.size() == 2 && (obs_q[0] !== nth_byte(s, 0) || obs_q[1] !== nth_byte(s, 1)))) begin
      bad++;
      $display("[TB] FAIL areset_rerun: got ended=%0d done=%b wr=%0d n=%0d want 1 1 1 2",
               ended, done, n_wr, obs_q.size());
    end
  endtask

  task automatic test_random();
    int at, ec, bl, lh, c, s_cyc, r_cyc;
    bit ended;
    logic [7:0] s;
    for (int it = 0; it < 5; it++) begin
      s = 8'($urandom);
      c = $urandom_range(1, 5);
      s_cyc = $urandom_range(0, 3);
      r_cyc = $urandom_range(0, 3);
      setup(s_cyc, r_cyc, 0);
      do_start(s, 8'(c), at);
      wait_end(500, ended, ec, bl, lh);
      total++;
      if (!ended || done !== 1'b1 || bl != 0 || n_rd != c || obs_q.size() != c) begin
        bad++;
        $display("[TB] FAIL rand%0d_seq: got ended=%0d done=%b rd=%0d n=%0d want 1 1 %0d %0d",
                 it, ended, done, n_rd, obs_q.size(), c, c);
      end else begin
        for (int i = 0; i < c; i++) begin
          total++;
          if (obs_q[i] !== nth_byte(s, i)) begin
            bad++;
            $display("[TB] FAIL rand%0d_byte%0d: got %h want %h", it, i, obs_q[i], nth_byte(s, i));
          end
        end
        total++;
        if (obs_cyc[0] - at != 5 + 2 * s_cyc + r_cyc) begin
          bad++;
          $display("[TB] FAIL rand%0d_latency: got %0d want %0d", it, obs_cyc[0] - at,
                   5 + 2 * s_cyc + r_cyc);
        end
      end
      total++;
      if (unstable != 0 || hold_bad != 0 || overlap_bad != 0 || proto_bad != 0 || bad_op != 0) begin
        bad++;
        $display("[TB] FAIL rand%0d_proto: got %0d %0d %0d %0d %0d want all 0", it,
                 unstable, hold_bad, overlap_bad, proto_bad, bad_op);
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_count_zero();
    test_stall_backpressure();
    test_timeout();
    test_start_while_busy();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
